// File: rtl/fetch_pc_predictor.sv
// Fetch PC generator with a direct-mapped BTB of 2-bit saturating counters.
// Define BPU_PERF_CNT_EN to add the branch_cnt / mispredict_cnt outputs.
module fetch_pc_predictor #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [1:0]  CTR_INIT    = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [31:0] pc_out,
  output logic        pred_taken,
  output logic [31:0] pred_target,
`ifdef BPU_PERF_CNT_EN
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt,
`endif
  output logic        flush
);

  localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = 30 - IDX;

  logic [29:0]     pc_q;
  logic            valid_q [BTB_ENTRIES];
  logic [TAGW-1:0] tag_q   [BTB_ENTRIES];
  logic [29:0]     tgt_q   [BTB_ENTRIES];
  logic [1:0]      ctr_q   [BTB_ENTRIES];

  logic [IDX-1:0]  l_idx, u_idx;
  logic [TAGW-1:0] u_tag;
  logic            l_hit, u_hit, mispredict, train;
  logic [31:0]     ex_pc_plus4;
  logic [29:0]     redirect;

  assign pc_out = {pc_q, 2'b00};

  always_comb begin
    l_idx       = pc_q[IDX-1:0];
    l_hit       = valid_q[l_idx] && (tag_q[l_idx] == pc_q[29:IDX]);
    pred_taken  = l_hit && ctr_q[l_idx][1];
    pred_target = pred_taken ? {tgt_q[l_idx], 2'b00} : {pc_q + 30'd1, 2'b00};
  end

  always_comb begin
    mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_target != ex_pred_target)));
    ex_pc_plus4 = ex_pc + 32'd4;
    redirect    = ex_taken ? ex_target[31:2] : ex_pc_plus4[31:2];
    u_idx       = ex_pc[IDX+1:2];
    u_tag       = ex_pc[31:IDX+2];
    u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    train       = ex_valid && ex_is_branch;
  end

  assign flush = mispredict;

  // A mispredict must redirect even while stalled, or the wrong path would be held.
  always_ff @(posedge clk) begin
    if (rst)             pc_q <= RESET_PC[31:2];
    else if (mispredict) pc_q <= redirect;
    else if (!stall)     pc_q <= pred_target[31:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else if (train) begin
      if (u_hit) begin
        if (ex_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
          tgt_q[u_idx] <= ex_target[31:2];
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
        end
      end else if (ex_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= ex_target[31:2];
        ctr_q[u_idx]   <= 2'b10;
      end
    end
  end

`ifdef BPU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (train)      branch_cnt     <= branch_cnt + 32'd1;
      if (mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end
`endif

endmodule
